// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM states, row geometry
// and the row-to-table-bit mapping (row 0 lands in the MSB).
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam int N_ROWS = 8;
   localparam int IN_W   = 3;

   localparam logic [IN_W-1:0] LAST_ROW = IN_W'(N_ROWS - 1);

   function automatic logic [IN_W-1:0] row_to_bit(input logic [IN_W-1:0] k);
      return LAST_ROW - k;
   endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable 8-bit up-counter that flags the last settle cycle of a row
// (count == SETTLE_CYCLES-1).
module settle_timer #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   logic [7:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 8'd0;
      end else if (clear) begin
         cnt <= 8'd0;
      end else if (enable) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign terminal = (cnt == 8'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input DUT through all 8 rows, samples its output after a settle
// window per row, and compares the assembled truth table with an expected word.
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [7:0]      expected,
   input  logic            dut_out,
   output logic [IN_W-1:0] dut_in,
   output logic            busy,
   output logic            done,
   output logic [7:0]      truth_table,
   output logic            match,
   output logic [7:0]      mismatch
);

   state_t          state;
   state_t          state_next;
   logic [IN_W-1:0] row;
   logic [7:0]      expected_q;
   logic [7:0]      table_cap;
   logic            timer_clear;
   logic            timer_en;
   logic            terminal;
   logic            accept;
   logic            abort_hit;
   logic            capture;
   logic            finish;

   settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (timer_clear),
      .enable   (timer_en),
      .terminal (terminal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Abort is checked before capture so a late abort never records the row.
   always_comb begin
      state_next  = state;
      timer_clear = 1'b0;
      timer_en    = 1'b0;
      accept      = 1'b0;
      abort_hit   = 1'b0;
      capture     = 1'b0;
      finish      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept      = 1'b1;
               timer_clear = 1'b1;
               state_next  = SETTLE;
            end
         end
         SETTLE: begin
            if (abort) begin
               abort_hit   = 1'b1;
               timer_clear = 1'b1;
               state_next  = IDLE;
            end else begin
               timer_en = 1'b1;
               if (terminal) begin
                  state_next = SAMPLE;
               end
            end
         end
         SAMPLE: begin
            timer_clear = 1'b1;
            if (abort) begin
               abort_hit  = 1'b1;
               state_next = IDLE;
            end else begin
               capture = 1'b1;
               if (row == LAST_ROW) begin
                  finish     = 1'b1;
                  state_next = DONE;
               end else begin
                  state_next = SETTLE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Table word as it will look once the current row's output is captured.
   always_comb begin
      table_cap                  = truth_table;
      table_cap[row_to_bit(row)] = dut_out;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row         <= '0;
         dut_in      <= '0;
         expected_q  <= 8'h00;
         truth_table <= 8'h00;
         match       <= 1'b0;
         mismatch    <= 8'h00;
      end else begin
         if (accept) begin
            expected_q  <= expected;
            truth_table <= 8'h00;
            match       <= 1'b0;
            mismatch    <= 8'h00;
            row         <= '0;
            dut_in      <= '0;
         end
         if (abort_hit) begin
            match    <= 1'b0;
            mismatch <= 8'h00;
            row      <= '0;
            dut_in   <= '0;
         end
         if (capture) begin
            truth_table <= table_cap;
            if (finish) begin
               match    <= (table_cap == expected_q);
               mismatch <= table_cap ^ expected_q;
               row      <= '0;
               dut_in   <= '0;
            end else begin
               row    <= row + 1'b1;
               dut_in <= row + 1'b1;
            end
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that exercises a 3-input combinational logic design under test (DUT) and characterises it. It drives the DUT inputs through all 8 input rows and waits a programmable settle time on each row. It then samples the DUT output and assembles an 8-bit truth-table word in the team's hex convention (for example 0x6F). The block sits between the scoring testbench/host and the synthesized gate netlist. It also compares the measured table against an expected value.

## Interface
- SETTLE_CYCLES, default 4: cycles the DUT inputs are held stable before sampling; legal range 1..255.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a sweep; honoured only in IDLE
- abort  in  1  cancel a sweep in progress; honoured in SETTLE/SAMPLE
- expected  in  8  expected truth table; latched on accepted start
- dut_out  in  1  DUT output
- dut_in  out  3  DUT inputs, registered; bit2=in1, bit1=in2, bit0=in3
- busy  out  1  high from accepted start until DONE exits
- done  out  1  one-cycle pulse when a sweep completes (not on abort)
- table  out  8  measured truth table; held until the next accepted start
- match  out  1  table == latched expected; valid while done=1 and held afterwards
- mismatch  out  8  table XOR latched expected; same validity as match

## Operation
- Row index k = {in1,in2,in3}, k = 0..7. The DUT output for row k is stored in table[7-k], so row 0 maps to the MSB.
  - Worked example: a DUT with out = in1 | (in2 ^ in3) yields 0x6F.
- FSM states are IDLE, SETTLE, SAMPLE and DONE.
- IDLE: dut_in=0, busy=0.
  - start=1 → latch expected, clear table/match/mismatch, row←0, cnt←0, go to SETTLE.
- SETTLE: dut_in=row, cnt increments each cycle.
  - cnt==SETTLE_CYCLES-1 → go to SAMPLE.
- SAMPLE: table[7-row]←dut_out.
  - If row==7 → go to DONE.
  - Otherwise row←row+1, cnt←0, go to SETTLE.
- DONE: done=1, match and mismatch updated from the completed table; next cycle go to IDLE.
- abort in SETTLE or SAMPLE → IDLE next edge.
  - dut_in←0, no done pulse.
  - table keeps its partial contents; match=0, mismatch=0.
  - abort has priority over the SAMPLE capture in the same cycle.
- start while busy is ignored; no queuing.
- start and abort together in IDLE → start wins; abort is a no-op in IDLE.
- rst at any time → IDLE immediately; all outputs go to their reset values.

## Timing
- Reset values: dut_in=0, busy=0, done=0, table=0x00, match=0, mismatch=0x00; state IDLE, row=0, cnt=0.
- dut_in changes only on clock edges and only at row transitions, so it never glitches.
- Per row: SETTLE_CYCLES cycles in SETTLE plus 1 cycle in SAMPLE. dut_out is sampled after SETTLE_CYCLES+1 full cycles of stable dut_in.
- Latency: done is high in the cycle starting 8×(SETTLE_CYCLES+1) edges after the edge that accepts start. With the default of 4 this is 40 cycles.
- busy rises on the accepting edge and falls on the edge after DONE. A new start is accepted at the earliest 1 cycle after done.
- Row counter is 3 bits; the sweep terminates on row==7, so there is no wrap.
- cnt is 8 bits.

## Structure
- Package tt_sweep_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - localparam N_ROWS=8 and IN_W=3;
  - function row_to_bit(k) = 7-k.
- Sub-module settle_timer: a loadable up-counter with a terminal flag at SETTLE_CYCLES-1, instantiated once.
- Everything else lives in the top FSM plus its result registers.

## Test plan
- Behavioural DUT out = in1 | (in2^in3), expected=0x6F, SETTLE_CYCLES=4, pulse start → done at cycle 40, table=0x6F, match=1, mismatch=0x00.
- DUT out = in1 & in2 & in3, expected=0x6F → table=0x01, match=0, mismatch=0x6E; dut_in visits 0..7 in order, each row held exactly 5 cycles.
- Abort raised while row=3 → IDLE next edge, dut_in=0, no done, busy=0, match=0. A following start produces a full, correct sweep.
- start pulsed again at cycles 10 and 39 of a sweep → ignored; a single done at 40. A start on the cycle after done is accepted.
- rst asserted asynchronously mid-SETTLE (between edges) → all outputs at reset values before the next clk edge; FSM returns to IDLE.
- SETTLE_CYCLES=1 with constant-1 DUT → done at cycle 16, table=0xFF.
